poly_pwm_synth: RTL and testbench

Parametrised polyphonic synthesiser sitting between the MIDI burst collector and the audio output pin. It captures a burst of up to VOICES note-on messages and decodes each note into a pitch class and an octave. It then runs one phase accumulator per voice, shapes and velocity-scales each voice, sums the voices and drives a 1-bit PWM output whose duty equals the summed sample.

---
 rtl/poly_pwm_synth.sv | 183 ++++++++++++++++++
 tb/tb_poly_pwm_synth.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/poly_pwm_synth.sv
// poly_pwm_synth: captures a burst of note-on messages and decodes each note into a pitch class and an octave.
// It runs one phase accumulator per voice and drives a 1-bit PWM whose duty is the
// velocity-scaled sum of all active voices.
module poly_pwm_synth #(
    parameter int VOICES  = 5,
    parameter int PHASE_W = 24,
    parameter int CLK_HZ  = 100_000_000
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            midi_burst_ready_in,
    input  logic [$clog2(VOICES+1)-1:0]     on_msg_count_in,
    input  logic [VOICES-1:0][31:0]         midi_burst_data_in,
    input  logic [1:0]                      wave_mode_in,
    output logic                            pwm_ready_out,
    output logic                            sig_out
);

    localparam int CNT_W  = $clog2(VOICES+1);
    localparam int SUM_W  = 8 + CNT_W;
    localparam int PERIOD = VOICES * 255;
    localparam int PCNT_W = $clog2(PERIOD);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_PLAY   = 2'd2;

    // Elaboration-time only: per-sample phase step for pitch class pc in octave 0 (MIDI note 0 = 8.1758 Hz).
    function automatic logic [PHASE_W-1:0] f_base_inc(input int pc);
        real r_sr;
        real r_x;
        int  v;
        r_sr = real'(CLK_HZ) / real'(PERIOD);
        r_x  = (2.0 ** real'(PHASE_W)) * 8.1758 * (2.0 ** (real'(pc) / 12.0)) / r_sr;
        v    = $rtoi(r_x + 0.5);
        return PHASE_W'(v);
    endfunction

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_count;
    logic [7:0]          r_note  [VOICES];
    logic [6:0]          r_vel   [VOICES];
    logic [3:0]          r_oct   [VOICES];
    logic [PHASE_W-1:0]  r_phase [VOICES];
    logic [PCNT_W-1:0]   r_pcnt;
    logic [SUM_W-1:0]    r_duty;
    logic [SUM_W-1:0]    r_sum;
    logic                r_sig;

    logic [PHASE_W-1:0]  w_base_inc [16];
    logic [PHASE_W-1:0]  w_inc      [VOICES];
    logic [7:0]          w_scaled   [VOICES];
    logic [VOICES-1:0]   w_in;
    logic [VOICES-1:0]   w_active;
    logic [VOICES-1:0]   w_big;
    logic [VOICES-1:0]   w_unused_bits;
    logic                w_unused;
    logic                w_any_big;
    logic                w_tick;
    logic [SUM_W-1:0]    w_sum;

    // Entries 12..15 can only be selected by a voice that is not played, so they are tied to 0.
    for (genvar g = 0; g < 16; g++) begin : g_tab
        localparam logic [PHASE_W-1:0] INC = (g < 12) ? f_base_inc(g) : '0;
        assign w_base_inc[g] = INC;
    end

    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        logic [7:0]  w_p;
        logic        w_m;
        logic [3:0]  w_pc;
        logic [7:0]  w_wave;
        logic [14:0] w_prod;

        assign w_p         = r_phase[g][PHASE_W-1 -: 8];
        assign w_m         = r_phase[g][PHASE_W-1];
        assign w_in[g]     = (r_count > CNT_W'(g));
        assign w_active[g] = w_in[g] && (r_vel[g] != 7'd0);
        assign w_big[g]    = (r_note[g] > 8'd11);
        assign w_pc        = w_big[g] ? 4'd0 : r_note[g][3:0];
        assign w_inc[g]    = w_base_inc[w_pc] << r_oct[g];
        assign w_unused_bits[g] = ^{midi_burst_data_in[g][31:16], midi_burst_data_in[g][7]};

        // Waveform shaper for this voice.
        always_comb begin
            w_wave = '0;
            case (wave_mode_in)
                2'd0:    w_wave = w_m ? 8'hFF : 8'h00;
                2'd1:    w_wave = w_p;
                2'd2:    w_wave = w_m ? ~{w_p[6:0], 1'b0} : {w_p[6:0], 1'b0};
                default: w_wave = '0;
            endcase
        end

        assign w_prod      = w_wave * r_vel[g];
        assign w_scaled[g] = w_prod[14:7];
    end

    assign w_unused  = ^w_unused_bits;
    assign w_any_big = |(w_active & w_big);
    assign w_tick    = (r_state == S_PLAY) && (r_pcnt == PCNT_W'(PERIOD - 1));

    // Mix of all active voices; it cannot exceed PERIOD, so it is never clipped.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < VOICES; i++)
            if (w_active[i]) w_sum = w_sum + SUM_W'(w_scaled[i]);
    end

    // Control FSM plus per-voice capture, decode and phase state; a burst strobe overrides everything.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
            r_count <= '0;
            for (int i = 0; i < VOICES; i++) begin
                r_note[i]  <= '0;
                r_vel[i]   <= '0;
                r_oct[i]   <= '0;
                r_phase[i] <= '0;
            end
        end else if (midi_burst_ready_in) begin
            r_count <= on_msg_count_in;
            for (int i = 0; i < VOICES; i++) begin
                r_note[i]  <= midi_burst_data_in[i][15:8];
                r_vel[i]   <= midi_burst_data_in[i][6:0];
                r_oct[i]   <= '0;
                r_phase[i] <= '0;
            end
            r_state <= (on_msg_count_in == '0) ? S_IDLE : S_DECODE;
        end else begin
            case (r_state)
                S_DECODE: begin
                    if (!w_any_big) r_state <= S_PLAY;
                    for (int i = 0; i < VOICES; i++)
                        if (w_in[i] && w_big[i]) begin
                            r_note[i] <= r_note[i] - 8'd12;
                            r_oct[i]  <= r_oct[i] + 4'd1;
                        end
                end
                S_PLAY: begin
                    if (w_tick)
                        for (int i = 0; i < VOICES; i++)
                            if (w_active[i]) r_phase[i] <= r_phase[i] + w_inc[i];
                end
                S_IDLE:  ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // PWM period counter; duty is latched once per period on the sample tick.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_pcnt <= '0;
            r_duty <= '0;
        end else if (midi_burst_ready_in || (r_state != S_PLAY)) begin
            r_pcnt <= '0;
            r_duty <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
            r_duty <= r_sum;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    // Registered mix: follows phase and mode changes one cycle later.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_sum <= '0;
        else         r_sum <= w_sum;
    end

    // PWM comparator output, one clock behind the counter, held low outside PLAY.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                  r_sig <= 1'b0;
        else if (midi_burst_ready_in) r_sig <= 1'b0;
        else                          r_sig <= (r_state == S_PLAY) && (32'(r_pcnt) < 32'(r_duty));
    end

    assign pwm_ready_out = (r_state == S_PLAY);
    assign sig_out       = r_sig;

endmodule

// File: tb/tb_poly_pwm_synth.sv
// Directed bench for poly_pwm_synth: table of bursts with hand-computed per-period duties,
// plus hand sequences for reset, decode, mode change, zero-count and tick-coincident bursts.
module tb_poly_pwm_synth;

    localparam int VOICES = 5;
    localparam int PERIOD = VOICES * 255;

    logic                    clk_in = 1'b0;
    logic                    rst_in;
    logic                    midi_burst_ready_in;
    logic [2:0]              on_msg_count_in;
    logic [VOICES-1:0][31:0] midi_burst_data_in;
    logic [1:0]              wave_mode_in;
    logic                    pwm_ready_out;
    logic                    sig_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    poly_pwm_synth #(.VOICES(VOICES), .PHASE_W(24), .CLK_HZ(100_000_000)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .midi_burst_ready_in (midi_burst_ready_in),
        .on_msg_count_in     (on_msg_count_in),
        .midi_burst_data_in  (midi_burst_data_in),
        .wave_mode_in        (wave_mode_in),
        .pwm_ready_out       (pwm_ready_out),
        .sig_out             (sig_out)
    );

    // One burst configuration with the sig_out high-count expected in each PWM period after PLAY entry.
    typedef struct packed {
        logic [2:0]        cnt;
        logic [7:0]        note;
        logic [4:0][7:0]   vel;
        logic [1:0]        mode;
        logic [3:0]        dcy;
        logic [3:0]        nper;
        logic [8:0][10:0]  ex;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic burst(input logic [2:0] cnt, input logic [4:0][7:0] notes, input logic [4:0][7:0] vels);
        for (int i = 0; i < VOICES; i++) midi_burst_data_in[i] = {16'h0, notes[i], vels[i]};
        on_msg_count_in     = cnt;
        midi_burst_ready_in = 1'b1;
        @(posedge clk_in); #1;
        midi_burst_ready_in = 1'b0;
    endtask

    // Cycles from the strobe edge until pwm_ready_out is seen high (bounded).
    task automatic wait_play(output int n);
        n = 0;
        do begin
            @(posedge clk_in); #1;
            n++;
        end while (!pwm_ready_out && n < 100);
    endtask

    task automatic period_hi(output int hi);
        hi = 0;
        repeat (PERIOD) begin
            @(posedge clk_in); #1;
            hi += int'(sig_out);
        end
    endtask

    initial begin
        int n;
        int hi;

        // note 127 -> pc 7, octave 10; inc = 2620 << 10 = 2682880 per tick
        tbl[0] = '{cnt:3'd1, note:8'd127, vel:{8'd0,8'd0,8'd0,8'd0,8'd127}, mode:2'd0, dcy:4'd11, nper:4'd9,
                   ex:{11'd0,11'd253,11'd253,11'd253,11'd0,11'd0,11'd0,11'd0,11'd0}};
        tbl[1] = '{cnt:3'd5, note:8'd127, vel:{5{8'd127}}, mode:2'd0, dcy:4'd11, nper:4'd6,
                   ex:{11'd0,11'd0,11'd0,11'd1265,11'd0,11'd0,11'd0,11'd0,11'd0}};
        tbl[2] = '{cnt:3'd3, note:8'd127, vel:{8'd127,8'd127,8'd0,8'h80,8'd0}, mode:2'd0, dcy:4'd1, nper:4'd7,
                   ex:'0};
        tbl[3] = '{cnt:3'd1, note:8'd127, vel:{8'd0,8'd0,8'd0,8'd0,8'd127}, mode:2'd1, dcy:4'd11, nper:4'd6,
                   ex:{11'd0,11'd0,11'd0,11'd161,11'd121,11'd80,11'd39,11'd0,11'd0}};
        tbl[4] = '{cnt:3'd1, note:8'd127, vel:{8'd0,8'd0,8'd0,8'd0,8'd127}, mode:2'd2, dcy:4'd11, nper:4'd6,
                   ex:{11'd0,11'd0,11'd0,11'd183,11'd242,11'd160,11'd79,11'd0,11'd0}};
        tbl[5] = '{cnt:3'd2, note:8'd127, vel:{8'd0,8'd0,8'd0,8'd64,8'd127}, mode:2'd0, dcy:4'd11, nper:4'd6,
                   ex:{11'd0,11'd0,11'd0,11'd380,11'd0,11'd0,11'd0,11'd0,11'd0}};

        rst_in              = 1'b0;
        midi_burst_ready_in = 1'b0;
        on_msg_count_in     = '0;
        midi_burst_data_in  = '0;
        wave_mode_in        = 2'd0;

        // reset state
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_ready", int'(pwm_ready_out), 0);
        chk("rst_sig", int'(sig_out), 0);
        #1 rst_in = 1'b1;
        repeat (5) @(posedge clk_in);
        #1;
        chk("idle_no_strobe", int'(pwm_ready_out), 0);

        // table-driven bursts
        for (int r = 0; r < 6; r++) begin
            wave_mode_in = tbl[r].mode;
            burst(tbl[r].cnt, {5{tbl[r].note}}, tbl[r].vel);
            wait_play(n);
            chk($sformatf("row%0d_decode_cycles", r), n, int'(tbl[r].dcy));
            for (int k = 0; k < int'(tbl[r].nper); k++) begin
                period_hi(hi);
                chk($sformatf("row%0d_period%0d_duty", r, k), hi, int'(tbl[r].ex[k]));
            end
            if (r == 1) begin
                // period 6 of the 5-voice chord has duty 1265: reset while sig_out is high
                repeat (10) @(posedge clk_in);
                #1;
                chk("pre_reset_sig_high", int'(sig_out), 1);
                #2 rst_in = 1'b0;
                #1;
                chk("async_rst_sig", int'(sig_out), 0);
                chk("async_rst_ready", int'(pwm_ready_out), 0);
                #2 rst_in = 1'b1;
                hi = 0;
                repeat (30) begin
                    @(posedge clk_in); #1;
                    hi += int'(sig_out) + int'(pwm_ready_out);
                end
                chk("post_reset_stays_idle", hi, 0);
            end
        end

        // zero-count burst during PLAY (period 6 of last row has duty 380)
        repeat (10) @(posedge clk_in);
        #1;
        chk("pre_zero_sig_high", int'(sig_out), 1);
        burst(3'd0, '0, '0);
        chk("zero_cnt_ready", int'(pwm_ready_out), 0);
        chk("zero_cnt_sig", int'(sig_out), 0);
        hi = 0;
        repeat (20) begin
            @(posedge clk_in); #1;
            hi += int'(sig_out) + int'(pwm_ready_out);
        end
        chk("zero_cnt_stays_idle", hi, 0);

        // decode: notes 60/0/127 -> (0,5) (0,0) (7,10), 11 cycles in DECODE
        burst(3'd3, {8'd0,8'd0,8'd127,8'd0,8'd60}, {8'd0,8'd0,8'd64,8'd64,8'd64});
        wait_play(n);
        chk("decode_cycles", n, 11);
        chk("dec_pc0", int'(dut.r_note[0]), 0);
        chk("dec_oct0", int'(dut.r_oct[0]), 5);
        chk("dec_pc1", int'(dut.r_note[1]), 0);
        chk("dec_oct1", int'(dut.r_oct[1]), 0);
        chk("dec_pc2", int'(dut.r_note[2]), 7);
        chk("dec_oct2", int'(dut.r_oct[2]), 10);

        // mode change saw -> mute inside period 3: that period keeps duty 80, the next one is 0
        wave_mode_in = 2'd1;
        burst(3'd1, {5{8'd127}}, {8'd0,8'd0,8'd0,8'd0,8'd127});
        wait_play(n);
        period_hi(hi);
        period_hi(hi);
        period_hi(hi);
        chk("mode_saw_period2", hi, 39);
        hi = 0;
        for (int j = 0; j < PERIOD; j++) begin
            if (j == 20) wave_mode_in = 2'd3;
            @(posedge clk_in); #1;
            hi += int'(sig_out);
        end
        chk("mode_switch_period3", hi, 80);
        period_hi(hi);
        chk("mode_mute_period4", hi, 0);

        // burst landing exactly on the second sample tick
        wave_mode_in = 2'd0;
        burst(3'd1, {5{8'd127}}, {8'd0,8'd0,8'd0,8'd0,8'd127});
        wait_play(n);
        repeat (2 * PERIOD - 1) begin
            @(posedge clk_in); #1;
        end
        chk("tick_pre_phase", int'(dut.r_phase[0]), 2682880);
        burst(3'd1, {5{8'd127}}, {8'd0,8'd0,8'd0,8'd0,8'd127});
        chk("tick_burst_ready", int'(pwm_ready_out), 0);
        chk("tick_burst_phase", int'(dut.r_phase[0]), 0);
        wait_play(n);
        chk("tick_burst_decode", n, 11);
        for (int k = 0; k < 6; k++) begin
            period_hi(hi);
            chk($sformatf("tick_burst_period%0d", k), hi, int'(tbl[0].ex[k]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
